mem_stage_ctrl: RTL and testbench

Parametrised successor to the fixed single-cycle MEM stage of the 5-stage pipeline, sitting between EXE and WB.
- Talks to an external multi-cycle data memory (SRAM or cache) over a req/ack handshake.
- Freezes the upstream pipeline while an access is outstanding.
- Inserts a bubble into the MEM/WB pipeline register during a freeze.
- Optionally retires stores through a one-entry store buffer.

---
 rtl/mem_stage_ctrl_pkg.sv | 21 ++
 rtl/mem_stage_ctrl_mem_wb.sv | 85 ++++++++
 rtl/mem_stage_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl_pkg
// Shared definitions for the MEM pipeline stage controller:
//   - default data / register-index / memory-address widths
//   - byte address mapped to external memory word 0
//   - access FSM state encoding (IDLE / ACCESS / DONE)
// -----------------------------------------------------------------------------
package mem_stage_ctrl_pkg;

   localparam int DATA_W_DEF     = 32;
   localparam int REG_ADDR_W_DEF = 4;
   localparam int MEM_ADDR_W_DEF = 16;
   localparam int BASE_ADDR_DEF  = 1024;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_DONE   = 2'b10
   } state_e;

endpackage : mem_stage_ctrl_pkg

// File: rtl/mem_stage_ctrl_mem_wb.sv
// -----------------------------------------------------------------------------
// mem_wb_reg
// MEM/WB pipeline register with bubble insertion.
//   bubble = 0 : load all inputs on the rising edge.
//   bubble = 1 : clear mem_read / wb_enable (a NOP reaches WB); the data fields
//                hold their previous values.
// Ports:
//   clk, rst (async, active-low)
//   bubble                          insert a NOP this edge
//   mem_read_in / wb_enable_in      control bits from MEM
//   dest_reg_in / alu_result_in     destination index and ALU result
//   mem_data_in                     load data
//   *_out                           registered copies towards WB
// -----------------------------------------------------------------------------
module mem_wb_reg
   import mem_stage_ctrl_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  bubble,
   input  logic                  mem_read_in,
   input  logic                  wb_enable_in,
   input  logic [REG_ADDR_W-1:0] dest_reg_in,
   input  logic [DATA_W-1:0]     alu_result_in,
   input  logic [DATA_W-1:0]     mem_data_in,
   output logic                  mem_read_out,
   output logic                  wb_enable_out,
   output logic [REG_ADDR_W-1:0] dest_reg_out,
   output logic [DATA_W-1:0]     alu_result_out,
   output logic [DATA_W-1:0]     memory_data_out
);

   logic                  mem_read_d,   mem_read_q;
   logic                  wb_enable_d,  wb_enable_q;
   logic [REG_ADDR_W-1:0] dest_reg_d,   dest_reg_q;
   logic [DATA_W-1:0]     alu_result_d, alu_result_q;
   logic [DATA_W-1:0]     mem_data_d,   mem_data_q;

   always_comb begin
      // NOTE: every signal gets a hold default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      mem_read_d   = mem_read_q;
      wb_enable_d  = wb_enable_q;
      dest_reg_d   = dest_reg_q;
      alu_result_d = alu_result_q;
      mem_data_d   = mem_data_q;
      if (bubble) begin
         mem_read_d  = 1'b0;
         wb_enable_d = 1'b0;
      end else begin
         mem_read_d   = mem_read_in;
         wb_enable_d  = wb_enable_in;
         dest_reg_d   = dest_reg_in;
         alu_result_d = alu_result_in;
         mem_data_d   = mem_data_in;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_read_q   <= 1'b0;
         wb_enable_q  <= 1'b0;
         dest_reg_q   <= '0;
         alu_result_q <= '0;
         mem_data_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         mem_read_q   <= mem_read_d;
         wb_enable_q  <= wb_enable_d;
         dest_reg_q   <= dest_reg_d;
         alu_result_q <= alu_result_d;
         mem_data_q   <= mem_data_d;
      end
   end

   assign mem_read_out    = mem_read_q;
   assign wb_enable_out   = wb_enable_q;
   assign dest_reg_out    = dest_reg_q;
   assign alu_result_out  = alu_result_q;
   assign memory_data_out = mem_data_q;

endmodule : mem_wb_reg

// File: rtl/mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl
// MEM pipeline stage between EXE and WB, driving a multi-cycle external data
// memory over a req/ack handshake. While an access is outstanding the upstream
// pipeline is frozen and NOPs are fed into the MEM/WB register.
//
// Optional feature (macro STORE_BUFFER_EN): a one-entry store buffer lets a
// store retire without freezing; the buffered write drains in the background.
// Any memory op that arrives while the buffer is full waits for it to drain.
//
// Ports:
//   clk, rst (async, active-low)
//   mem_read_in, mem_write_in, wb_enable_in, dest_reg_in, alu_result_in,
//   store_data_in                      instruction fields from EXE/MEM
//   freeze_out                         hold IF/ID/EXE
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_ack, mem_rdata      external memory handshake
//   mem_read_out, wb_enable_out, alu_result_out, dest_reg_out,
//   memory_data_out                    MEM/WB register towards WB
// -----------------------------------------------------------------------------
module mem_stage_ctrl
   import mem_stage_ctrl_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int REG_ADDR_W = REG_ADDR_W_DEF,
   parameter int MEM_ADDR_W = MEM_ADDR_W_DEF,
   parameter int BASE_ADDR  = BASE_ADDR_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_read_in,
   input  logic                  mem_write_in,
   input  logic                  wb_enable_in,
   input  logic [REG_ADDR_W-1:0] dest_reg_in,
   input  logic [DATA_W-1:0]     alu_result_in,
   input  logic [DATA_W-1:0]     store_data_in,
   output logic                  freeze_out,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [MEM_ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic                  mem_ack,
   input  logic [DATA_W-1:0]     mem_rdata,
   output logic                  mem_read_out,
   output logic                  wb_enable_out,
   output logic [DATA_W-1:0]     alu_result_out,
   output logic [REG_ADDR_W-1:0] dest_reg_out,
   output logic [DATA_W-1:0]     memory_data_out
);

   state_e                state_q, state_d;
   logic                  mem_req_d,   mem_req_q;
   logic                  mem_we_d,    mem_we_q;
   logic [MEM_ADDR_W-1:0] mem_addr_d,  mem_addr_q;
   logic [DATA_W-1:0]     mem_wdata_d, mem_wdata_q;
   logic [DATA_W-1:0]     rdata_d,     rdata_q;

   logic                  is_mem_op;
   logic                  start_access;  // IDLE -> ACCESS this edge
   logic                  sb_capture;    // store absorbed by the buffer
   logic                  idle_freeze;   // freeze contribution while in IDLE
   logic [DATA_W-1:0]     byte_off;
   logic [MEM_ADDR_W-1:0] word_addr;

   assign is_mem_op = mem_read_in | mem_write_in;

   // Byte address relative to memory word 0; low two bits dropped.
   assign byte_off  = alu_result_in - DATA_W'(BASE_ADDR);
   assign word_addr = MEM_ADDR_W'(byte_off >> 2);

`ifdef STORE_BUFFER_EN
   logic sb_valid_d, sb_valid_q;

   // A store (write wins over read) goes to an empty buffer without freezing;
   // only loads use the FSM, and only once the buffer is empty.
   assign sb_capture   = mem_write_in & ~sb_valid_q;
   assign start_access = mem_read_in & ~mem_write_in & ~sb_valid_q;
   assign idle_freeze  = is_mem_op & ~sb_capture;
`else
   assign sb_capture   = 1'b0;
   assign start_access = is_mem_op;
   assign idle_freeze  = is_mem_op;
`endif

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   if (start_access) state_d = ST_ACCESS;
         ST_ACCESS: if (mem_ack)      state_d = ST_DONE;
         ST_DONE:                     state_d = ST_IDLE;
         default:                     state_d = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      freeze_out = 1'b0;
      unique case (state_q)
         ST_IDLE:   freeze_out = idle_freeze;
         ST_ACCESS: freeze_out = 1'b1;
         default:   freeze_out = 1'b0;
      endcase
   end

   // ---------------- Memory port and load data ----------------
   always_comb begin
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rdata_d     = rdata_q;
`ifdef STORE_BUFFER_EN
      sb_valid_d  = sb_valid_q;
`endif

      // Launch a request; the buffer shares the same port registers.
      if (state_q == ST_IDLE && (start_access || sb_capture)) begin
         mem_req_d   = 1'b1;
         mem_we_d    = mem_write_in;
         mem_addr_d  = word_addr;
         mem_wdata_d = store_data_in;
`ifdef STORE_BUFFER_EN
         sb_valid_d  = sb_capture;
`endif
      end

      // Acks are accepted only for the foreground access (or a buffered store).
      if (state_q == ST_ACCESS && mem_ack) begin
         mem_req_d = 1'b0;
         rdata_d   = mem_rdata;
      end

`ifdef STORE_BUFFER_EN
      if (sb_valid_q && mem_ack) begin
         mem_req_d  = 1'b0;
         sb_valid_d = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
      end else begin
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rdata_q     <= rdata_d;
      end
   end

`ifdef STORE_BUFFER_EN
   // A buffered store is dropped by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sb_valid_q <= 1'b0;
      else      sb_valid_q <= sb_valid_d;
   end
`endif

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

   // ---------------- MEM/WB pipeline register ----------------
   mem_wb_reg #(
      .DATA_W     (DATA_W),
      .REG_ADDR_W (REG_ADDR_W)
   ) u_mem_wb_reg (
      .clk             (clk),
      .rst             (rst),
      .bubble          (freeze_out),
      .mem_read_in     (mem_read_in),
      .wb_enable_in    (wb_enable_in),
      .dest_reg_in     (dest_reg_in),
      .alu_result_in   (alu_result_in),
      .mem_data_in     (rdata_q),
      .mem_read_out    (mem_read_out),
      .wb_enable_out   (wb_enable_out),
      .dest_reg_out    (dest_reg_out),
      .alu_result_out  (alu_result_out),
      .memory_data_out (memory_data_out)
   );

endmodule : mem_stage_ctrl

// File: tb/tb_mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_ctrl
// Directed bench for mem_stage_ctrl: reset, ALU pass-through, loads with
// various wait states, zero-wait store, spurious ack, reset mid-access and,
// with STORE_BUFFER_EN, a buffered store followed by a load.
// Inputs are driven 1 time unit after the rising edge; combinational outputs
// are sampled on the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_stage_ctrl;

   logic        clk;
   logic        rst;
   logic        mem_read_in;
   logic        mem_write_in;
   logic        wb_enable_in;
   logic [3:0]  dest_reg_in;
   logic [31:0] alu_result_in;
   logic [31:0] store_data_in;
   logic        freeze_out;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        mem_read_out;
   logic        wb_enable_out;
   logic [31:0] alu_result_out;
   logic [3:0]  dest_reg_out;
   logic [31:0] memory_data_out;

   int          n_cmp;
   int          n_err;
   int          fcnt;
   logic [31:0] last_rdata;

   mem_stage_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .mem_read_in     (mem_read_in),
      .mem_write_in    (mem_write_in),
      .wb_enable_in    (wb_enable_in),
      .dest_reg_in     (dest_reg_in),
      .alu_result_in   (alu_result_in),
      .store_data_in   (store_data_in),
      .freeze_out      (freeze_out),
      .mem_req         (mem_req),
      .mem_we          (mem_we),
      .mem_addr        (mem_addr),
      .mem_wdata       (mem_wdata),
      .mem_ack         (mem_ack),
      .mem_rdata       (mem_rdata),
      .mem_read_out    (mem_read_out),
      .wb_enable_out   (wb_enable_out),
      .alu_result_out  (alu_result_out),
      .dest_reg_out    (dest_reg_out),
      .memory_data_out (memory_data_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      mem_read_in   = 1'b0;
      mem_write_in  = 1'b0;
      wb_enable_in  = 1'b0;
      dest_reg_in   = 4'd0;
      alu_result_in = 32'd0;
      store_data_in = 32'd0;
   endtask

   // Load from byte address 'addr'; memory acks after 'waits' non-ack ACCESS
   // cycles. Expected freeze length is one IDLE cycle plus waits+1 ACCESS cycles.
   task automatic run_load(input logic [31:0] addr, input int waits, input logic [31:0] rdata,
                           input logic [15:0] exp_addr, input logic [3:0] dest);
      int f;
      f = 0;
      mem_read_in   = 1'b1;
      mem_write_in  = 1'b0;
      wb_enable_in  = 1'b1;
      dest_reg_in   = dest;
      alu_result_in = addr;
      store_data_in = 32'd0;
      @(negedge clk);
      if (freeze_out) f++;
      chk("ld_idle_req", mem_req, 1'b0);
      for (int c = 0; c <= waits; c++) begin
         tick();
         if (c == waits) begin
            mem_ack   = 1'b1;
            mem_rdata = rdata;
         end
         @(negedge clk);
         if (freeze_out) f++;
         chk("ld_req", mem_req, 1'b1);
         chk("ld_we", mem_we, 1'b0);
         chk("ld_addr", mem_addr, exp_addr);
         chk("ld_bubble_wb", wb_enable_out, 1'b0);
      end
      tick();
      mem_ack   = 1'b0;
      mem_rdata = 32'd0;
      @(negedge clk);
      chk("ld_done_freeze", freeze_out, 1'b0);
      chk("ld_done_req", mem_req, 1'b0);
      chk("ld_freeze_cycles", f, waits + 2);
      tick();
      chk("ld_data", memory_data_out, rdata);
      chk("ld_mem_read_out", mem_read_out, 1'b1);
      chk("ld_wb_en_out", wb_enable_out, 1'b1);
      chk("ld_dest_out", dest_reg_out, dest);
      chk("ld_alu_out", alu_result_out, addr);
      last_rdata = rdata;
      clear_inputs();
   endtask

   initial begin
      n_cmp      = 0;
      n_err      = 0;
      last_rdata = 32'd0;
      rst        = 1'b0;
      mem_ack    = 1'b0;
      mem_rdata  = 32'd0;
      clear_inputs();

      // ---- 1. reset state, then an ALU op ----
      repeat (2) @(negedge clk);
      chk("rst_req", mem_req, 1'b0);
      chk("rst_we", mem_we, 1'b0);
      chk("rst_addr", mem_addr, 16'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      chk("rst_freeze", freeze_out, 1'b0);
      chk("rst_wb_en", wb_enable_out, 1'b0);
      chk("rst_mdata", memory_data_out, 32'd0);
      rst = 1'b1;
      tick();
      wb_enable_in  = 1'b1;
      dest_reg_in   = 4'd5;
      alu_result_in = 32'h2A;
      @(negedge clk);
      chk("alu_freeze", freeze_out, 1'b0);
      tick();
      chk("alu_wb_en", wb_enable_out, 1'b1);
      chk("alu_dest", dest_reg_out, 4'd5);
      chk("alu_result", alu_result_out, 32'h2A);
      chk("alu_mem_read", mem_read_out, 1'b0);
      clear_inputs();
      tick();

      // ---- 2. load at 0x408, ack after 3 wait cycles -> 5 freeze cycles ----
      run_load(32'h408, 3, 32'hDEADBEEF, 16'd2, 4'd3);
      tick();

`ifndef STORE_BUFFER_EN
      // ---- 3. zero-wait store of 0x1234 to 0x400 -> 2 freeze cycles ----
      fcnt          = 0;
      mem_write_in  = 1'b1;
      alu_result_in = 32'h400;
      store_data_in = 32'h1234;
      @(negedge clk);
      if (freeze_out) fcnt++;
      tick();
      mem_ack = 1'b1;
      @(negedge clk);
      if (freeze_out) fcnt++;
      chk("st_req", mem_req, 1'b1);
      chk("st_we", mem_we, 1'b1);
      chk("st_addr", mem_addr, 16'd0);
      chk("st_wdata", mem_wdata, 32'h1234);
      tick();
      mem_ack = 1'b0;
      @(negedge clk);
      if (freeze_out) fcnt++;
      chk("st_done_req", mem_req, 1'b0);
      chk("st_freeze_cycles", fcnt, 2);
      tick();
      last_rdata = 32'd0;
      clear_inputs();
      tick();
`endif

      // ---- 4. spurious ack in IDLE alongside an ALU op, then a load ----
      mem_ack       = 1'b1;
      mem_rdata     = 32'hBAD0BAD0;
      wb_enable_in  = 1'b1;
      dest_reg_in   = 4'd9;
      alu_result_in = 32'h77;
      @(negedge clk);
      chk("spur_freeze", freeze_out, 1'b0);
      chk("spur_req", mem_req, 1'b0);
      tick();
      mem_ack   = 1'b0;
      mem_rdata = 32'd0;
      chk("spur_mdata", memory_data_out, last_rdata);
      chk("spur_alu", alu_result_out, 32'h77);
      chk("spur_dest", dest_reg_out, 4'd9);
      clear_inputs();
      @(negedge clk);
      chk("spur_after_req", mem_req, 1'b0);
      chk("spur_after_freeze", freeze_out, 1'b0);
      tick();
      run_load(32'h40C, 1, 32'hCAFEF00D, 16'd3, 4'd4);
      tick();

      // ---- 5. reset asserted in the second ACCESS cycle ----
      mem_read_in   = 1'b1;
      wb_enable_in  = 1'b1;
      dest_reg_in   = 4'd7;
      alu_result_in = 32'h410;
      tick();
      tick();
      @(negedge clk);
      chk("abort_req_before", mem_req, 1'b1);
      #1;
      rst = 1'b0;
      #1;
      chk("abort_req", mem_req, 1'b0);
      chk("abort_we", mem_we, 1'b0);
      chk("abort_addr", mem_addr, 16'd0);
      chk("abort_wdata", mem_wdata, 32'd0);
      chk("abort_mem_read_out", mem_read_out, 1'b0);
      chk("abort_wb_en_out", wb_enable_out, 1'b0);
      chk("abort_alu_out", alu_result_out, 32'd0);
      chk("abort_dest_out", dest_reg_out, 4'd0);
      chk("abort_mdata", memory_data_out, 32'd0);
      chk("abort_freeze_op", freeze_out, 1'b1);
      clear_inputs();
      #1;
      chk("abort_freeze_noop", freeze_out, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      tick();
      // Freeze count of 2 only holds if the FSM restarted from IDLE.
      run_load(32'h414, 0, 32'h0F0F0F0F, 16'd5, 4'd2);
      tick();

`ifdef STORE_BUFFER_EN
      // ---- 6. buffered store then a load; memory acks the store late ----
      mem_write_in  = 1'b1;
      alu_result_in = 32'h420;
      store_data_in = 32'h5555AAAA;
      @(negedge clk);
      chk("sb_store_freeze", freeze_out, 1'b0);
      tick();
      clear_inputs();
      mem_read_in   = 1'b1;
      wb_enable_in  = 1'b1;
      dest_reg_in   = 4'd6;
      alu_result_in = 32'h424;
      fcnt          = 0;
      for (int d = 1; d <= 4; d++) begin
         if (d == 4) mem_ack = 1'b1;
         @(negedge clk);
         if (freeze_out) fcnt++;
         chk("sb_req", mem_req, 1'b1);
         chk("sb_we", mem_we, 1'b1);
         chk("sb_addr", mem_addr, 16'd8);
         chk("sb_wdata", mem_wdata, 32'h5555AAAA);
         tick();
      end
      mem_ack = 1'b0;
      chk("sb_drain_freeze_cycles", fcnt, 4);
      run_load(32'h424, 0, 32'h13579BDF, 16'd9, 4'd6);
      tick();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_mem_stage_ctrl
